// File: rtl/seq_player_pkg.sv
// seq_player_pkg: command/state encodings and the position step helper shared by the player controller.
package seq_player_pkg;
  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_BACK  = 2'b01;
  localparam logic [1:0] CMD_FWD   = 2'b10;
  localparam logic [1:0] CMD_FAULT = 2'b11;
  localparam logic [3:0] POS_FAULT = 4'hF;
  typedef enum logic [2:0] {PAUSED, STEP_PEND, PLAY, FAULT, RECOVER} state_e;
  function automatic logic [3:0] pos_step(input logic [3:0] p, input logic back, input logic [3:0] last);
    return back ? (p == 4'd0 ? last : p - 4'd1) : (p == last ? 4'd0 : p + 4'd1);
  endfunction
endpackage

// File: rtl/seq_btn_sync.sv
// seq_btn_sync: two-flop synchronizer followed by a rising-edge strobe.
module seq_btn_sync (
  input  logic clock,
  input  logic reset,
  input  logic din_i,
  output logic rise_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[1:0], din_i};
  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/seq_player_ctrl.sv
// seq_player_ctrl: turns board buttons and a fault request into tick-aligned stepper commands,
// mirroring the stepper position so auto-play can stop or wrap at the sequence ends.
module seq_player_ctrl
  import seq_player_pkg::*;
#(
  parameter int SEQ_LEN = 9,
  parameter bit WRAP    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_play,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       dir,
  input  logic [1:0] speed,
  input  logic       fault_in,
  input  logic       fault_clr,
  output logic [1:0] cmd,
  output logic [3:0] pos,
  output logic       playing,
  output logic       faulted
);
  localparam logic [3:0] LAST = 4'(SEQ_LEN - 1);
  // event bit order: [3] fault_clr, [2] play, [1] fwd, [0] back
  logic [3:0] rise, ev_all, ev, pend_q, pend_d;
  logic [3:0] lvl_s1_q, lvl_s2_q;
  logic       fault_s, dir_s;
  logic [1:0] speed_s;
  state_e     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [2:0] tcnt_q, tcnt_d, per_m1;
  logic       sdir_q, sdir_d;
  logic       clr_e, play_e, fwd_e, back_e, due, stop;
  seq_btn_sync u_clr  (.clock(clock), .reset(reset), .din_i(fault_clr), .rise_o(rise[3]));
  seq_btn_sync u_play (.clock(clock), .reset(reset), .din_i(btn_play),  .rise_o(rise[2]));
  seq_btn_sync u_fwd  (.clock(clock), .reset(reset), .din_i(btn_fwd),   .rise_o(rise[1]));
  seq_btn_sync u_back (.clock(clock), .reset(reset), .din_i(btn_back),  .rise_o(rise[0]));
  assign {fault_s, dir_s, speed_s} = lvl_s2_q;
  // events landing on a tick are parked one cycle so the tick action is never disturbed
  assign ev_all = rise | pend_q;
  assign pend_d = tick ? ev_all : 4'b0;
  assign ev     = tick ? 4'b0 : ev_all;
  assign clr_e  = ev[3];
  assign play_e = ev[2] & ~ev[3];
  assign fwd_e  = ev[1] & ~|ev[3:2];
  assign back_e = ev[0] & ~|ev[3:1];
  assign per_m1 = (3'd1 << speed_s) - 3'd1;
  assign due    = tcnt_q >= per_m1;
  assign stop   = !WRAP && (dir_s ? pos_q == 4'd0 : pos_q == LAST);
  assign playing = state_q == PLAY;
  assign faulted = state_q == FAULT;
  assign pos     = faulted ? POS_FAULT : pos_q;
  assign cmd = state_q == STEP_PEND ? (sdir_q ? CMD_BACK : CMD_FWD) :
               state_q == PLAY      ? (due && !stop ? (dir_s ? CMD_BACK : CMD_FWD) : CMD_HOLD) :
               state_q == FAULT     ? CMD_FAULT :
               state_q == RECOVER   ? CMD_FWD : CMD_HOLD;
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tcnt_d  = tcnt_q;
    sdir_d  = sdir_q;
    if (fault_s) state_d = FAULT;
    else
      case (state_q)
        PAUSED:
          if (play_e) begin
            state_d = PLAY;
            tcnt_d  = 3'd0;
          end else if (fwd_e || back_e) begin
            state_d = STEP_PEND;
            sdir_d  = back_e;
          end
        STEP_PEND:
          if (tick) begin
            pos_d   = pos_step(pos_q, sdir_q, LAST);
            state_d = PAUSED;
          end
        PLAY:
          if (tick) begin
            tcnt_d = due ? 3'd0 : tcnt_q + 3'd1;
            if (due && stop) state_d = PAUSED;
            else if (due) pos_d = pos_step(pos_q, dir_s, LAST);
          end else if (play_e) state_d = PAUSED;
        FAULT:
          if (clr_e) state_d = RECOVER;
        RECOVER:
          if (tick) begin
            pos_d   = 4'd0;
            state_d = PAUSED;
          end
        default: state_d = PAUSED;
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lvl_s1_q <= '0;
      lvl_s2_q <= '0;
      state_q  <= PAUSED;
      pos_q    <= '0;
      tcnt_q   <= '0;
      sdir_q   <= 1'b0;
      pend_q   <= '0;
    end else begin
      lvl_s1_q <= {fault_in, dir, speed};
      lvl_s2_q <= lvl_s1_q;
      state_q  <= state_d;
      pos_q    <= pos_d;
      tcnt_q   <= tcnt_d;
      sdir_q   <= sdir_d;
      pend_q   <= pend_d;
    end
endmodule

// File: doc/seq_player_ctrl.md
Name: seq_player_ctrl

Overview:
- Controller that drives the 2-bit command input of the digit-sequence stepper: 00 hold, 01 back, 10 forward, 11 force fault state.
- Turns synchronized button presses and a fault input into commands aligned to the divider's slow tick, so the stepper and its 7-segment decoder can run in manual step, auto-play or fault-recovery modes.
- Sits between the board inputs, the frequency-divider tick and the stepper.
- Keeps a mirrored position index so auto-play can stop at the ends of the sequence.

Parameters:
- SEQ_LEN, 9, number of sequence positions; pos range is 0..SEQ_LEN-1.
- WRAP, 1, 1 = auto-play wraps around at the ends; 0 = auto-play stops at the end and pauses.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-cycle strobe from the divider; the stepper consumes cmd on this cycle.
- btn_play  in  1  raw play/pause button, level.
- btn_fwd  in  1  raw step-forward button, level.
- btn_back  in  1  raw step-back button, level.
- dir  in  1  auto-play direction, 0 = forward, 1 = reverse; sampled when a play step is issued.
- speed  in  2  auto-play period, 2^speed ticks per step (1, 2, 4 or 8).
- fault_in  in  1  fault request, level.
- fault_clr  in  1  fault clear button, level.
- cmd  out  2  command to the stepper.
- pos  out  4  mirrored sequence index; 4'hF while in fault.
- playing  out  1  high in PLAY.
- faulted  out  1  high in FAULT.

Behaviour:
- Reset values: state PAUSED, cmd 00, pos 0, tcnt 0, playing 0, faulted 0, no pending events.
- Input synchronization:
  - Every input except tick goes through a 2-flop synchronizer.
  - Buttons are rising-edge detected after synchronization.
  - An input rising at edge n produces an event acted on at edge n+3.
- cmd is decoded only from registered state; there is no combinational path from any input.
- States and transitions:
  - PAUSED: cmd 00.
    - play event → PLAY, tcnt 0.
    - fwd event → STEP_PEND with sdir fwd.
    - back event → STEP_PEND with sdir back.
  - STEP_PEND: cmd is 10 (fwd) or 01 (back).
    - On tick: pos updates by ±1 with wrap, state → PAUSED.
    - Button events in this state are ignored.
  - PLAY: cmd is the dir command when tcnt == 2^speed-1, else 00.
    - Each tick increments tcnt.
    - On a tick with tcnt == 2^speed-1: tcnt → 0 and pos updates.
    - Play event → PAUSED.
    - Step events are ignored.
    - If speed drops below the current tcnt, the step is issued on the next tick and tcnt → 0.
  - FAULT: cmd 11, pos 4'hF, faulted 1.
    - fault_clr event while synchronized fault_in is low → RECOVER.
    - fault_clr event while fault_in is still high is ignored.
  - RECOVER: cmd 10 (the stepper's fault state goes to position 0).
    - On tick: pos 0, state → PAUSED.
- Fault entry: synchronized fault_in high moves any state to FAULT on the next edge. It is never deferred and has the highest priority.
- Event priority within one cycle: fault_in > fault_clr > play > fwd > back. Lower-priority simultaneous events are dropped.
- Tick coincidence:
  - Tick consumption is applied first.
  - A button event on a tick cycle is held in a one-deep pending flag per button and applied on the following cycle.
- Position arithmetic:
  - Forward: pos == SEQ_LEN-1 → 0, else +1.
  - Back: pos == 0 → SEQ_LEN-1, else -1.
  - Manual steps always wrap.
- WRAP = 0, auto-play end stop:
  - In PLAY, when the next step would wrap (fwd at SEQ_LEN-1, or rev at 0), no command is issued.
  - At that tick the state → PAUSED, playing 0, cmd 00.
- reset asserted in any state: all outputs and state return to reset values immediately, including mid-STEP_PEND and mid-FAULT.

Decomposition:
- Package seq_player_pkg holds:
  - cmd encodings: CMD_HOLD = 00, CMD_BACK = 01, CMD_FWD = 10, CMD_FAULT = 11.
  - State encodings: PAUSED, STEP_PEND, PLAY, FAULT, RECOVER.
  - POS_FAULT = 4'hF.
- One sub-module, seq_btn_sync: 2-flop synchronizer plus rising-edge detector with asynchronous reset. It is instantiated for btn_play, btn_fwd, btn_back and fault_clr. fault_in uses the synchronizer part only.

Test Plan:
- Manual step forward: after reset, pulse btn_fwd, no tick → cmd 10 three cycles after the press; after the next tick, pos 0→1 and cmd returns to 00.
- Manual step back: at pos 0, pulse btn_back, then tick → pos 8, cmd 00, state PAUSED.
- Auto-play with wrap: WRAP=1, speed=2, dir=0, pulse btn_play → playing 1; cmd 10 only during every 4th tick; pos steps 0,1,…,8,0; a second play press → playing 0, cmd 00.
- End stop: WRAP=0, speed=0, dir=0, start at pos 6, play → pos reaches 8; on the next tick cmd stays 00 and playing drops to 0.
- Fault and recovery: fault_in high during PLAY → cmd 11, pos F, faulted 1; fault_clr pulsed while fault_in high → no change; fault_in low then fault_clr → cmd 10; next tick → pos 0, PAUSED.
- Reset and tick coincidence: reset asserted in STEP_PEND → cmd 00, pos 0 asynchronously; btn_fwd event landing on a tick cycle → STEP_PEND entered one cycle later, pos unchanged by that tick.
